fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Control sequencer of the FFT core: starts when the AXI bridge reports a complete frame in sample RAM, issues radix-2 decimation-in-frequency butterflies for every stage, and raises the calculation-end flag the bridge waits on before streaming results out. Each butterfly is issued as an address pair plus twiddle index over a valid/ready handshake to the butterfly datapath. Between stages it waits for all in-place writebacks to complete. Results remain in RAM in bit-reversed order; reordering is outside this block.

## Interface
- No parameters; widths fixed: sample index 12 bits, N ≤ 4096.
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_DATA_LOADED  in  1  frame-loaded strobe from the bridge; start request
- i_SAMPLES_NUMBER  in  12  N; sampled on an accepted start
- i_BFLY_READY  in  1  datapath accepts the current butterfly
- i_BFLY_DONE  in  1  one issued butterfly has written back to RAM
- o_BFLY_VALID  out  1  butterfly command valid
- o_ADDR_A  out  12  upper-wing RAM index
- o_ADDR_B  out  12  lower-wing RAM index (o_ADDR_A + half)
- o_TWIDDLE_IDX  out  11  index into the N/2-entry twiddle ROM
- o_STAGE  out  4  current stage, 0..L-1
- o_BUSY  out  1  high in ISSUE or DRAIN
- o_CALC_END  out  1  level; frame transform complete
- o_ERR  out  1  level; last start had an illegal N
- o_CYCLES  out  24  cycle count of last run (see Configuration)

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. Reset → IDLE; all outputs 0; all counters 0.
- Start is accepted only in IDLE or DONE. It latches N, clears o_CALC_END and o_ERR, and computes L = log2(N).
- Legal N is a power of two with 2 ≤ N ≤ 4096 (exactly one bit set, bit 0 clear). Illegal N sets o_ERR, issues nothing, and leaves the block in IDLE.
- i_DATA_LOADED in ISSUE or DRAIN is ignored.
- ISSUE: butterfly counter k runs 0..N/2-1 per stage s. half = N >> (s+1).
  - a = ((k & ~(half-1)) << 1) | (k & (half-1))
  - b = a | half
  - tw = (k & (half-1)) << s
- k advances only on o_BFLY_VALID && i_BFLY_READY. On acceptance of k = N/2-1 → DRAIN.
- Outstanding counter (12 bits): +1 per accept, -1 per i_BFLY_DONE. Both in the same cycle leave it unchanged. i_BFLY_DONE with outstanding = 0 is ignored, with no underflow.
- DRAIN exits when outstanding = 0:
  - s < L-1: increment s, clear k, go to ISSUE.
  - s = L-1: go to DONE.
- DONE: o_CALC_END = 1, held until the next accepted start. o_STAGE holds L-1.
- Reset at any point aborts the run immediately and returns to IDLE with outputs 0.

## Timing
- Start seen at the edge ending cycle T → o_BUSY=1 and o_BFLY_VALID=1 with stage 0, k=0 in cycle T+1.
- Outputs are registered. While o_BFLY_VALID=1 and i_BFLY_READY=0, o_ADDR_A, o_ADDR_B, o_TWIDDLE_IDX and o_STAGE hold stable.
- With i_BFLY_READY held high, throughput is 1 butterfly/cycle.
- o_BFLY_VALID is 0 in DRAIN, IDLE and DONE.
- DRAIN seeing outstanding = 0 in cycle D → next ISSUE valid in cycle D+1, or o_CALC_END=1 in cycle D+1.
- Minimum DRAIN residence is 1 cycle, even when outstanding is already 0.

## Configuration
- FFT_SEQ_CYCLE_CNT_EN defined:
  - A 24-bit counter clears on an accepted start and counts every cycle in ISSUE or DRAIN, saturating at 2^24-1.
  - o_CYCLES updates on entry to DONE and holds until the next DONE.
- Undefined: the counter is not built and o_CYCLES is tied to 0.

## Test plan
- N=8, ready always 1, done 2 cycles after each accept:
  - stage 0: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - then o_CALC_END=1 and held.
- N=2 → single butterfly (0,1,0), o_STAGE=0, then DONE. N=12 and N=1 → o_ERR=1, o_BFLY_VALID never asserted, state IDLE.
- Random i_BFLY_READY backpressure on N=16 → command fields stable while stalled; 32 accepts total, no duplicates or skips.
- Done pulses withheld for 10 cycles after the last stage-0 accept → no stage-1 issue until outstanding reaches 0. A simultaneous accept and done leaves the count unchanged.
- i_rst asserted mid-stage-1 of N=64 → all outputs 0 immediately; a fresh start runs a full 6-stage transform.
- N=4096 → 12 stages, 24576 accepts, last command (4094,4095,0). With FFT_SEQ_CYCLE_CNT_EN, zero done latency and ready=1 → o_CYCLES = 24576 + 12.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: radix-2 DIF butterfly issue sequencer; optional cycle counter under FFT_SEQ_CYCLE_CNT_EN.
// i_SAMPLES_NUMBER = 0 encodes N = 4096, which does not fit in 12 bits.
module fft_stage_sequencer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_DATA_LOADED,
  input  logic [11:0] i_SAMPLES_NUMBER,
  input  logic        i_BFLY_READY,
  input  logic        i_BFLY_DONE,
  output logic        o_BFLY_VALID,
  output logic [11:0] o_ADDR_A,
  output logic [11:0] o_ADDR_B,
  output logic [10:0] o_TWIDDLE_IDX,
  output logic [3:0]  o_STAGE,
  output logic        o_BUSY,
  output logic        o_CALC_END,
  output logic        o_ERR,
  output logic [23:0] o_CYCLES
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t      state_q, state_d;
  logic [12:0] n_q, n_d, n_in;
  logic [3:0]  l_q, l_d, s_q, s_d, l_in;
  logic [11:0] k_q, k_d, out_q, out_d, a_q, a_d, b_q, b_d, half, hm;
  logic [10:0] tw_q, tw_d;
  logic        valid_q, valid_d, busy_q, busy_d, end_q, end_d, err_q, err_d;
  logic        legal, start, accept, last_k;
  always_comb begin
    n_in = (i_SAMPLES_NUMBER == 12'd0) ? 13'd4096 : {1'b0, i_SAMPLES_NUMBER};
    legal = ~|(n_in & (n_in - 13'd1)) && !n_in[0];
    l_in = 4'd0;
    for (int i = 1; i < 13; i++) if (n_in[i]) l_in = 4'(i);
    start = i_DATA_LOADED && (state_q == IDLE || state_q == DONE);
    accept = valid_q && i_BFLY_READY;
    last_k = k_q == n_q[12:1] - 12'd1;
    // a simultaneous accept and writeback cancel; a writeback with nothing outstanding is dropped
    out_d = (accept && !i_BFLY_DONE) ? out_q + 12'd1 :
            (!accept && i_BFLY_DONE && out_q != 12'd0) ? out_q - 12'd1 : out_q;
    state_d = state_q;
    n_d = n_q;
    l_d = l_q;
    s_d = s_q;
    k_d = k_q;
    end_d = end_q;
    err_d = err_q;
    if (start) begin
      n_d = n_in;
      l_d = l_in;
      s_d = 4'd0;
      k_d = 12'd0;
      end_d = 1'b0;
      err_d = !legal;
      state_d = legal ? ISSUE : IDLE;
    end else if (state_q == ISSUE && accept) begin
      k_d = k_q + 12'd1;
      state_d = last_k ? DRAIN : ISSUE;
    end else if (state_q == DRAIN && out_q == 12'd0) begin
      if (s_q == l_q - 4'd1) begin
        state_d = DONE;
        end_d = 1'b1;
      end else begin
        s_d = s_q + 4'd1;
        k_d = 12'd0;
        state_d = ISSUE;
      end
    end
    half = 12'(n_d >> (s_d + 4'd1));
    hm = half - 12'd1;
    a_d = (state_d == ISSUE) ? ((k_d & ~hm) << 1) | (k_d & hm) : a_q;
    b_d = (state_d == ISSUE) ? ((k_d & ~hm) << 1) | (k_d & hm) | half : b_q;
    tw_d = (state_d == ISSUE) ? 11'((k_d & hm) << s_d) : tw_q;
    valid_d = state_d == ISSUE;
    busy_d = state_d == ISSUE || state_d == DRAIN;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      n_q <= '0;
      l_q <= '0;
      s_q <= '0;
      k_q <= '0;
      out_q <= '0;
      a_q <= '0;
      b_q <= '0;
      tw_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      end_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      l_q <= l_d;
      s_q <= s_d;
      k_q <= k_d;
      out_q <= out_d;
      a_q <= a_d;
      b_q <= b_d;
      tw_q <= tw_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      end_q <= end_d;
      err_q <= err_d;
    end
  end
  assign o_BFLY_VALID = valid_q;
  assign o_ADDR_A = a_q;
  assign o_ADDR_B = b_q;
  assign o_TWIDDLE_IDX = tw_q;
  assign o_STAGE = s_q;
  assign o_BUSY = busy_q;
  assign o_CALC_END = end_q;
  assign o_ERR = err_q;
`ifdef FFT_SEQ_CYCLE_CNT_EN
  logic [23:0] cnt_q, cnt_d, cyc_q, cyc_d;
  always_comb begin
    cnt_d = start ? 24'd0 : (busy_q && cnt_q != 24'hFFFFFF) ? cnt_q + 24'd1 : cnt_q;
    cyc_d = (state_d == DONE && state_q != DONE) ? cnt_d : cyc_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
    end
  end
  assign o_CYCLES = cyc_q;
`else
  assign o_CYCLES = 24'd0;
`endif
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: scoreboard bench; expected butterflies come from a group/offset DIF loop model.
module tb_fft_stage_sequencer;
  logic        i_clk = 1'b0, i_rst = 1'b1, i_DATA_LOADED = 1'b0, i_BFLY_READY = 1'b0, i_BFLY_DONE = 1'b0;
  logic [11:0] i_SAMPLES_NUMBER = 12'd0;
  logic        o_BFLY_VALID, o_BUSY, o_CALC_END, o_ERR;
  logic [11:0] o_ADDR_A, o_ADDR_B;
  logic [10:0] o_TWIDDLE_IDX;
  logic [3:0]  o_STAGE;
  logic [23:0] o_CYCLES;
  typedef struct packed {logic [11:0] a; logic [11:0] b; logic [10:0] tw; logic [3:0] st;} cmd_t;
  cmd_t exp_q[$];
  int   due_q[$];
  int   tests = 0, fails = 0, cyc = 0, lat = 2, accepts = 0;
  bit   rnd = 0, hold = 0, spur = 0, stall = 0, r_e, acc_e, dn_e;
  cmd_t prev, last;
  fft_stage_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_DATA_LOADED(i_DATA_LOADED), .i_SAMPLES_NUMBER(i_SAMPLES_NUMBER),
    .i_BFLY_READY(i_BFLY_READY), .i_BFLY_DONE(i_BFLY_DONE), .o_BFLY_VALID(o_BFLY_VALID),
    .o_ADDR_A(o_ADDR_A), .o_ADDR_B(o_ADDR_B), .o_TWIDDLE_IDX(o_TWIDDLE_IDX), .o_STAGE(o_STAGE),
    .o_BUSY(o_BUSY), .o_CALC_END(o_CALC_END), .o_ERR(o_ERR), .o_CYCLES(o_CYCLES)
  );
  always #5 i_clk = ~i_clk;
  function automatic cmd_t cur();
    return {o_ADDR_A, o_ADDR_B, o_TWIDDLE_IDX, o_STAGE};
  endfunction
  // datapath model: ready/backpressure, delayed writebacks, and scoreboard pop on every accept
  always @(negedge i_clk) begin
    cyc++;
    if (stall) begin
      tests++;
      if (cur() !== prev) begin fails++; $display("FAIL stall_hold: got %h want %h", cur(), prev); end
    end
    r_e = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    acc_e = o_BFLY_VALID && r_e;
    if (acc_e) begin
      tests++;
      accepts++;
      last = cur();
      if (exp_q.size() == 0) begin fails++; $display("FAIL cmd_extra: got %h want none", cur()); end
      else begin
        if (cur() !== exp_q[0]) begin fails++; $display("FAIL cmd: got %h want %h", cur(), exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    if (lat == 0) dn_e = acc_e;
    else begin
      if (acc_e) due_q.push_back(cyc + lat);
      dn_e = !hold && due_q.size() > 0 && due_q[0] <= cyc;
      if (dn_e) void'(due_q.pop_front());
    end
    i_BFLY_READY = r_e;
    i_BFLY_DONE = dn_e | spur;
    stall = o_BFLY_VALID && !r_e;
    prev = cur();
  end
  task automatic tick();
    @(negedge i_clk);
    #2;
  endtask
  task automatic push_cmds(input int n);
    int l = $clog2(n);
    for (int s = 0; s < l; s++) begin
      int h = n >> (s + 1);
      for (int g = 0; g < n; g += 2 * h)
        for (int j = 0; j < h; j++) exp_q.push_back(cmd_t'{12'(g + j), 12'(g + j + h), 11'(j << s), 4'(s)});
    end
  endtask
  task automatic start(input int n);
    tick();
    i_SAMPLES_NUMBER = 12'(n);
    i_DATA_LOADED = 1'b1;
    tick();
    i_DATA_LOADED = 1'b0;
  endtask
  task automatic wait_end(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      ok = o_CALC_END;
    end
  endtask
  task automatic test_reset();
    tick();
    tick();
    tests++;
    if ({o_BFLY_VALID, o_BUSY, o_CALC_END, o_ERR} !== 4'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {o_BFLY_VALID, o_BUSY, o_CALC_END, o_ERR});
    end
    tests++;
    if (cur() !== '0 || o_CYCLES !== 24'd0) begin fails++; $display("FAIL reset_fields: got %h/%h want 0", cur(), o_CYCLES); end
    i_rst = 1'b0;
    spur = 1;
    repeat (3) tick();
    spur = 0;
  endtask
  task automatic test_n8();
    bit ok;
    lat = 2;
    push_cmds(8);
    start(8);
    tests++;
    if (!(o_BUSY && o_BFLY_VALID) || cur() !== cmd_t'{12'd0, 12'd4, 11'd0, 4'd0}) begin
      fails++; $display("FAIL n8_first: got v%b b%b %h want v1 b1 first cmd", o_BFLY_VALID, o_BUSY, cur());
    end
    wait_end(200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL n8_end: got calc_end 0 want 1"); end
    tests++;
    if (exp_q.size() != 0 || o_STAGE !== 4'd2 || o_BUSY || o_BFLY_VALID) begin
      fails++; $display("FAIL n8_done: got left %0d stage %0d busy %b want 0 2 0", exp_q.size(), o_STAGE, o_BUSY);
    end
    repeat (5) tick();
    tests++;
    if (o_CALC_END !== 1'b1 || o_STAGE !== 4'd2) begin fails++; $display("FAIL n8_hold: got %b/%0d want 1/2", o_CALC_END, o_STAGE); end
  endtask
  task automatic test_back_to_back();
    bit ok;
    lat = 0;
    push_cmds(2);
    start(2);
    tests++;
    if (o_CALC_END !== 1'b0 || !o_BFLY_VALID || cur() !== cmd_t'{12'd0, 12'd1, 11'd0, 4'd0}) begin
      fails++; $display("FAIL n2_first: got end %b v %b %h want 0 1 first cmd", o_CALC_END, o_BFLY_VALID, cur());
    end
    wait_end(20, ok);
    tests++;
    if (!ok || exp_q.size() != 0 || o_STAGE !== 4'd0) begin
      fails++; $display("FAIL n2_done: got end %b left %0d stage %0d want 1 0 0", ok, exp_q.size(), o_STAGE);
    end
    tests++;
`ifdef FFT_SEQ_CYCLE_CNT_EN
    if (o_CYCLES !== 24'd2) begin fails++; $display("FAIL n2_cycles: got %0d want 2", o_CYCLES); end
`else
    if (o_CYCLES !== 24'd0) begin fails++; $display("FAIL n2_cycles: got %0d want 0", o_CYCLES); end
`endif
  endtask
  task automatic test_illegal();
    int ns[2] = '{12, 1};
    bit quiet;
    foreach (ns[i]) begin
      start(ns[i]);
      tests++;
      if (o_ERR !== 1'b1 || o_CALC_END !== 1'b0 || o_BUSY !== 1'b0) begin
        fails++; $display("FAIL illegal_%0d: got err %b end %b busy %b want 1 0 0", ns[i], o_ERR, o_CALC_END, o_BUSY);
      end
      quiet = 1;
      repeat (5) begin tick(); if (o_BFLY_VALID || o_BUSY) quiet = 0; end
      tests++;
      if (!quiet) begin fails++; $display("FAIL illegal_quiet_%0d: got activity want none", ns[i]); end
    end
  endtask
  task automatic test_backpressure();
    bit ok;
    int base = accepts;
    rnd = 1;
    lat = 2;
    push_cmds(16);
    start(16);
    tests++;
    if (o_ERR !== 1'b0 || o_BUSY !== 1'b1) begin fails++; $display("FAIL bp_start: got err %b busy %b want 0 1", o_ERR, o_BUSY); end
    repeat (4) tick();
    i_SAMPLES_NUMBER = 12'd4;
    i_DATA_LOADED = 1'b1;
    tick();
    i_DATA_LOADED = 1'b0;
    wait_end(500, ok);
    tests++;
    if (!ok || accepts - base != 32 || exp_q.size() != 0 || o_STAGE !== 4'd3) begin
      fails++; $display("FAIL bp_done: got end %b acc %0d stage %0d want 1 32 3", ok, accepts - base, o_STAGE);
    end
    rnd = 0;
    tick();
  endtask
  task automatic test_withheld_done();
    bit ok, held = 1;
    int base = accepts;
    lat = 3;
    push_cmds(8);
    start(8);
    for (int i = 0; i < 50 && accepts < base + 4; i++) tick();
    hold = 1;
    repeat (10) begin tick(); if (o_STAGE !== 4'd0 || o_BFLY_VALID || !o_BUSY) held = 0; end
    tests++;
    if (!held) begin fails++; $display("FAIL drain_wait: got stage %0d valid %b want 0 0 while writebacks pending", o_STAGE, o_BFLY_VALID); end
    hold = 0;
    wait_end(200, ok);
    tests++;
    if (!ok || exp_q.size() != 0) begin fails++; $display("FAIL drain_end: got end %b left %0d want 1 0", ok, exp_q.size()); end
  endtask
  task automatic test_reset_midrun();
    bit ok;
    lat = 1;
    push_cmds(64);
    start(64);
    for (int i = 0; i < 200 && o_STAGE != 4'd1; i++) tick();
    repeat (3) tick();
    tests++;
    if (o_STAGE !== 4'd1) begin fails++; $display("FAIL rst_reach: got stage %0d want 1", o_STAGE); end
    i_rst = 1'b1;
    stall = 0;
    #1;
    tests++;
    if ({o_BFLY_VALID, o_BUSY, o_CALC_END, o_ERR} !== 4'b0 || cur() !== '0) begin
      fails++; $display("FAIL rst_async: got %b %h want 0", {o_BFLY_VALID, o_BUSY, o_CALC_END, o_ERR}, cur());
    end
    exp_q.delete();
    due_q.delete();
    tick();
    i_rst = 1'b0;
    push_cmds(64);
    start(64);
    wait_end(2000, ok);
    tests++;
    if (!ok || exp_q.size() != 0 || o_STAGE !== 4'd5) begin
      fails++; $display("FAIL rst_rerun: got end %b left %0d stage %0d want 1 0 5", ok, exp_q.size(), o_STAGE);
    end
  endtask
  task automatic test_n4096();
    bit ok;
    int base = accepts;
    lat = 0;
    push_cmds(4096);
    start(0);
    wait_end(30000, ok);
    tests++;
    if (!ok || accepts - base != 24576 || exp_q.size() != 0 || o_STAGE !== 4'd11) begin
      fails++; $display("FAIL n4096: got end %b acc %0d stage %0d want 1 24576 11", ok, accepts - base, o_STAGE);
    end
    tests++;
    if (last !== cmd_t'{12'd4094, 12'd4095, 11'd0, 4'd11}) begin fails++; $display("FAIL n4096_last: got %h want (4094,4095,0)", last); end
    tests++;
`ifdef FFT_SEQ_CYCLE_CNT_EN
    if (o_CYCLES !== 24'd24588) begin fails++; $display("FAIL n4096_cycles: got %0d want 24588", o_CYCLES); end
`else
    if (o_CYCLES !== 24'd0) begin fails++; $display("FAIL n4096_cycles: got %0d want 0", o_CYCLES); end
`endif
  endtask
  initial begin
    test_reset();
    test_n8();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_withheld_done();
    test_reset_midrun();
    test_n4096();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
